// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types and constants for the multi-cycle ALU.
//   alu_op_e : ALUOp encoding (3 bits)
//   state_e  : control FSM states (IDLE, COMPUTE, DONE)
//   FLAG_*   : bit positions of N, Z, C, V inside ALUFlags
package alu_mc_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_ORR = 3'b011,
      OP_ADC = 3'b100,
      OP_BIC = 3'b101,
      OP_MUL = 3'b110,
      OP_DIV = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the control unit and alu_mc.
//   master (control unit): drives Start, ALUOp, Src_A, Src_B, C_Flag
//   slave  (alu_mc)      : drives Busy, Done, Result, ResultHi, ALUFlags
//
// Handshake: a Start seen at a rising edge while Busy=0 is accepted and
// samples ALUOp/Src_A/Src_B/C_Flag at that edge; a Start while Busy=1 is
// dropped. Done pulses for exactly one cycle when the results of the
// accepted operation appear; Result/ResultHi/ALUFlags then hold until the
// next accepted operation completes. Start may be raised in the Done cycle.
interface alu_mc_if #(parameter int WIDTH = 32);
   import alu_mc_pkg::*;

   logic             Start;
   alu_op_e          ALUOp;
   logic [WIDTH-1:0] Src_A;
   logic [WIDTH-1:0] Src_B;
   logic             C_Flag;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] ResultHi;
   logic [3:0]       ALUFlags;

   modport master (
      output Start, ALUOp, Src_A, Src_B, C_Flag,
      input  Busy, Done, Result, ResultHi, ALUFlags
   );

   modport slave (
      input  Start, ALUOp, Src_A, Src_B, C_Flag,
      output Busy, Done, Result, ResultHi, ALUFlags
   );

endinterface

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative engine for unsigned MUL and DIV.
// One {hi,lo} shift register pair, one adder/subtractor and a down-counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture operands (lo <= a_i, hi <= 0, counter <= WIDTH-1)
//   step_i        : perform one iteration
//   div_i         : operation captured on load is DIV (else MUL)
//   a_i, b_i      : operands
//   last_o        : the iteration performed this cycle is the final one
//   div_zero_o    : captured op is DIV with divisor 0
//   hi_o, lo_o    : register contents after this cycle's iteration
// Macro ALU_MC_DIV_EN: when undefined, only the multiplier path is built.
module alu_mc_iter #(parameter int WIDTH = 32) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
   logic [CW-1:0]    cnt_q;

`ifdef ALU_MC_DIV_EN
   logic             div_q;
   logic [WIDTH:0]   x;
   logic [WIDTH:0]   y;
   logic [WIDTH+1:0] sum;

   // MUL adds B to hi; DIV subtracts B from {hi, next dividend bit}.
   // For DIV the top sum bit is the no-borrow indicator (partial >= B).
   always_comb begin
      x   = div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
      y   = div_q ? ~{1'b0, b_q} : {1'b0, b_q};
      sum = {1'b0, x} + {1'b0, y} + {{(WIDTH+1){1'b0}}, div_q};
      if (div_q) begin
         // Restoring step: keep the difference only when it did not borrow.
         hi_d = sum[WIDTH+1] ? sum[WIDTH-1:0] : x[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], sum[WIDTH+1]};
      end else begin
         {hi_d, lo_d} = lo_q[0] ? {sum[WIDTH:0], lo_q[WIDTH-1:1]}
                                : {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     div_q <= 1'b0;
      else if (load_i) div_q <= div_i;
   end

   assign div_zero_o = div_q && (b_q == '0);
`else
   logic [WIDTH:0] sum;
   logic           unused_div;

   always_comb begin
      sum = {1'b0, hi_q} + {1'b0, b_q};
      {hi_d, lo_d} = lo_q[0] ? {sum, lo_q[WIDTH-1:1]}
                             : {1'b0, hi_q, lo_q[WIDTH-1:1]};
   end

   assign unused_div = div_i;
   assign div_zero_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         hi_q  <= '0;
         lo_q  <= a_i;
         b_q   <= b_i;
         cnt_q <= CW'(WIDTH - 1);
      end else if (step_i) begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign last_o = (cnt_q == '0);
   assign hi_o   = hi_d;
   assign lo_o   = lo_d;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle ADD/SUB/AND/ORR/ADC/BIC, iterative
// unsigned MUL/DIV (WIDTH iterations) through alu_mc_iter.
//   CLK     : clock, rising edge
//   RESETn  : asynchronous active-low reset
//   bus     : alu_mc_if slave modport (Start/ALUOp/operands in,
//             Busy/Done/Result/ResultHi/ALUFlags out)
//   state_o : current control FSM state, for observation
// Macro ALU_MC_DIV_EN: builds the divider; when undefined, DIV completes
// in one cycle with Result=0, ResultHi=0, ALUFlags=4'b0101.
module alu_mc import alu_mc_pkg::*; #(parameter int WIDTH = 32) (
   input  logic   CLK,
   input  logic   RESETn,
   alu_mc_if.slave bus,
   output state_e state_o
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
   logic [3:0]       flags_q, flags_d;
   logic             out_we, iter_load, iter_op;

   logic [WIDTH-1:0] b_op, sc_res;
   logic [WIDTH:0]   sum;
   logic             is_sub, cin, sc_c, sc_v;

   logic [WIDTH-1:0] it_hi, it_lo;
   logic             it_last, it_dz;

`ifdef ALU_MC_DIV_EN
   assign iter_op = (bus.ALUOp == OP_MUL) || (bus.ALUOp == OP_DIV);
`else
   assign iter_op = (bus.ALUOp == OP_MUL);
`endif

   // Single-cycle datapath. SUB reuses the adder as A + ~B + 1, so the
   // ADD overflow rule applied to the inverted B also covers SUB.
   always_comb begin
      is_sub = (bus.ALUOp == OP_SUB);
      b_op   = is_sub ? ~bus.Src_B : bus.Src_B;
      cin    = is_sub | ((bus.ALUOp == OP_ADC) & bus.C_Flag);
      sum    = {1'b0, bus.Src_A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (bus.ALUOp)
         OP_ADD, OP_SUB, OP_ADC: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (bus.Src_A[WIDTH-1] ~^ b_op[WIDTH-1]) &
                     (bus.Src_A[WIDTH-1] ^ sum[WIDTH-1]);
         end
         OP_AND:  sc_res = bus.Src_A & bus.Src_B;
         OP_ORR:  sc_res = bus.Src_A | bus.Src_B;
         OP_BIC:  sc_res = bus.Src_A & ~bus.Src_B;
`ifndef ALU_MC_DIV_EN
         OP_DIV:  sc_v   = 1'b1;   // marks DIV as unsupported in this build
`endif
         default: ;
      endcase
   end

   // Control FSM: next state, iterator load and output-register write.
   always_comb begin
      state_d   = state_q;
      iter_load = 1'b0;
      out_we    = 1'b0;
      res_d     = sc_res;
      hi_d      = '0;
      flags_d   = '0;
      flags_d[FLAG_N] = sc_res[WIDTH-1];
      flags_d[FLAG_Z] = (sc_res == '0);
      flags_d[FLAG_C] = sc_c;
      flags_d[FLAG_V] = sc_v;
      case (state_q)
         IDLE, DONE: begin
            if (bus.Start) begin
               if (iter_op) begin
                  state_d   = COMPUTE;
                  iter_load = 1'b1;
               end else begin
                  state_d = DONE;
                  out_we  = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         COMPUTE: begin
            res_d   = it_lo;
            hi_d    = it_hi;
            flags_d = '0;
            flags_d[FLAG_N] = it_lo[WIDTH-1];
            flags_d[FLAG_Z] = (it_lo == '0);
            flags_d[FLAG_V] = it_dz;
            if (it_last) begin
               state_d = DONE;
               out_we  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= IDLE;
         res_q   <= '0;
         hi_q    <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         if (out_we) begin
            res_q   <= res_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
         end
      end
   end

   alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
      .clk_i      (CLK),
      .rst_ni     (RESETn),
      .load_i     (iter_load),
      .step_i     (state_q == COMPUTE),
      .div_i      (bus.ALUOp == OP_DIV),
      .a_i        (bus.Src_A),
      .b_i        (bus.Src_B),
      .last_o     (it_last),
      .div_zero_o (it_dz),
      .hi_o       (it_hi),
      .lo_o       (it_lo)
   );

   assign bus.Busy     = (state_q == COMPUTE);
   assign bus.Done     = (state_q == DONE);
   assign bus.Result   = res_q;
   assign bus.ResultHi = hi_q;
   assign bus.ALUFlags = flags_q;
   assign state_o      = state_q;

endmodule
